cam_bin_capture: RTL
====================

Name: cam_bin_capture

Overview:
- Parametrised capture front-end for the camera line follower.
- Takes the raw OV-style YUV422 byte stream (vsync/href/8-bit data) on the pixel clock and keeps only luma bytes, with optional horizontal decimation.
- Binarises each kept pixel against a runtime threshold, with optional inversion, and packs the bits into WORD_W-bit words.
- Writes the words to the frame buffer (SP256K-style RAM port) and reports per-frame status to the SPI/readout side.

Parameters:
- LINE_PIX, 32: maximum luma pixels kept per line after decimation; extra pixels are dropped.
- MAX_LINES, 64: maximum lines stored per frame; extra lines are dropped.
- WORD_W, 16: packed word width; must divide LINE_PIX.
- ADDR_W, 14: buffer address width.
- Y_FIRST, 1: 1 = luma is the first byte of each href byte pair; 0 = second byte.
- DECIM_W, 2: width of the decimation control.

Ports:
- cam_pclk  in  1  sole clock; all inputs are sampled on the rising edge.
- nreset  in  1  synchronous, active-low reset.
- cam_vsync  in  1  frame sync; falling edge starts a frame, rising edge ends it.
- cam_href  in  1  line valid.
- cam_data  in  8  pixel byte.
- thresh  in  8  luma threshold.
- invert  in  1  1 = dark pixel gives a 1 bit.
- decim  in  DECIM_W  keep one luma of every (decim+1).
- mem_we  out  1  buffer write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  WORD_W  packed word.
- frame_done  out  1  one-cycle pulse when a frame is complete.
- lines_captured  out  ADDR_W  lines stored in the last frame.
- words_written  out  ADDR_W  words stored in the last frame.
- overflow  out  1  sticky: a line or pixel limit was hit during the frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters and the pack register cleared.
- Reset mid-frame aborts the frame. No write is issued and no frame_done is pulsed.
- Edge detect: previous vsync and href are registered. Falling edge = prev 1 and current 0.
- FSM: IDLE -> (vsync fall) ARMED -> (href rise) LINE -> (href fall) FLUSH -> ARMED. From ARMED, LINE or FLUSH: vsync rise -> END -> IDLE.
- Entering ARMED from IDLE clears mem_addr, line count, word count and overflow.
- LINE state:
  - A byte phase toggle starts at 0 on each href rise. The luma byte is the phase-0 byte when Y_FIRST=1, the phase-1 byte otherwise.
  - A decimation counter restarts at 0 each line. Only luma bytes with counter == 0 are kept; the counter wraps at decim.
  - Kept bit = (cam_data >= thresh) XOR invert.
  - Bits are packed LSB-first: the first kept pixel of the word is bit 0.
- Write timing:
  - On the cycle after the WORD_W-th bit of a word is sampled: mem_we=1 for one cycle, with mem_wdata = the packed word and mem_addr = the current address.
  - The address increments after each write.
- Line limits:
  - Kept pixels beyond LINE_PIX in a line are discarded and set overflow.
  - A line beginning when the line count == MAX_LINES is discarded entirely and sets overflow.
- FLUSH (one cycle):
  - If the partial bit count is nonzero, write the word zero-padded in its upper bits.
  - Increment the line count if the line held at least one kept pixel.
- Address wrap: when mem_addr reaches 2^ADDR_W-1 and a write occurs, the address saturates (no wrap) and overflow is set.
- vsync rise while href is still high: FLUSH runs first, then END. frame_done is delayed one cycle accordingly.
- END: lines_captured and words_written are latched and frame_done is pulsed for one cycle. Status outputs hold until the next END.
- vsync fall outside IDLE is ignored.
- All arithmetic is unsigned. Counters are sized with $clog2 of their limit plus 1.

Decomposition:
- Package cam_pkg holds the FSM state enum (IDLE, ARMED, LINE, FLUSH, END) and the YUV byte-phase constants. It is shared with the SPI readout block.
- One sub-module, bit_packer: serial-in, WORD_W-wide, with word-ready and flush-with-zero-pad. The FSM, edge detection and counters stay in the top of this block.

Test Plan:
- thresh=128, invert=0, decim=0, Y_FIRST=1; one frame with two lines of 32 luma values alternating 50/200 (then 40/180), UV=128 -> 4 writes at addresses 0..3, each 0xAAAA; frame_done pulses once; lines_captured=2, words_written=4, overflow=0.
- Same stimulus with invert=1 -> all four words are 0x5555.
- decim=1 on the line-0 pattern (50,200,50,200...) -> kept pixels are all 50, giving 16 zero bits -> 1 write of 0x0000 per line.
- Line of 20 luma pixels all 255 -> writes 0xFFFF then a flush word of 0x000F at the next address.
- MAX_LINES=2 with a 3-line frame -> words_written=4, lines_captured=2, overflow=1. Then nreset low for one cycle mid-next-frame -> all outputs 0 and no frame_done.
- vsync rises while href is high after 8 pixels of 200 -> flush write of 0x00FF, then frame_done one cycle later.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture front-end and the SPI readout block:
// capture FSM states and YUV422 byte-phase constants.
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LINE,
        FLUSH,
        END
    } cam_state_e;

    // Byte position within each href byte pair
    localparam logic PHASE_FIRST  = 1'b0;
    localparam logic PHASE_SECOND = 1'b1;

    function automatic logic luma_phase(input bit y_first);
        return y_first ? PHASE_FIRST : PHASE_SECOND;
    endfunction

endpackage

// File: rtl/cam_bin_capture_if.sv
// Camera-side inputs, runtime controls, frame-buffer write port and frame status
// of the capture block, bundled with capture-side (slave) and source-side (master) views.
interface cam_bin_capture_if #(
    parameter int ADDR_W  = 14,
    parameter int WORD_W  = 16,
    parameter int DECIM_W = 2
);
    logic               cam_vsync;
    logic               cam_href;
    logic [7:0]         cam_data;
    logic [7:0]         thresh;
    logic               invert;
    logic [DECIM_W-1:0] decim;

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [WORD_W-1:0]  mem_wdata;
    logic               frame_done;
    logic [ADDR_W-1:0]  lines_captured;
    logic [ADDR_W-1:0]  words_written;
    logic               overflow;

    modport master (
        output cam_vsync, cam_href, cam_data, thresh, invert, decim,
        input  mem_we, mem_addr, mem_wdata, frame_done, lines_captured,
               words_written, overflow
    );

    modport slave (
        input  cam_vsync, cam_href, cam_data, thresh, invert, decim,
        output mem_we, mem_addr, mem_wdata, frame_done, lines_captured,
               words_written, overflow
    );

endinterface

// File: rtl/cam_bin_capture_bit_packer.sv
// Serial-in, LSB-first bit packer: emits a registered word one cycle after its
// last bit arrives, or a zero-padded partial word on flush.
module bit_packer #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              i_clear,
    input  logic              i_bit_valid,
    input  logic              i_bit,
    input  logic              i_flush,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_word;
    logic              r_valid;
    logic [WORD_W-1:0] w_full;

    // NOTE: default assignment first, then the override, so no latch can be inferred.
    always_comb begin
        w_full        = r_shift;
        w_full[r_cnt] = i_bit;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!nreset || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_bit_valid) begin
                if (r_cnt == LAST) begin
                    r_word  <= w_full;
                    r_valid <= 1'b1;
                    r_shift <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_shift[r_cnt] <= i_bit;
                    r_cnt          <= r_cnt + 1'b1;
                end
            end else if (i_flush && (r_cnt != '0)) begin
                // Upper bits of r_shift are still zero from the last emission
                r_word  <= r_shift;
                r_valid <= 1'b1;
                r_shift <= '0;
                r_cnt   <= '0;
            end
        end
    end

    assign o_word_valid = r_valid;
    assign o_word       = r_word;

endmodule

// File: rtl/cam_bin_capture.sv
// Camera capture front-end: extracts luma from a YUV422 byte stream, decimates,
// binarises and packs pixels into words written to the frame buffer, with per-frame status.
module cam_bin_capture
    import cam_pkg::*;
#(
    parameter int LINE_PIX  = 32,
    parameter int MAX_LINES = 64,
    parameter int WORD_W    = 16,
    parameter int ADDR_W    = 14,
    parameter bit Y_FIRST   = 1'b1,
    parameter int DECIM_W   = 2
) (
    input  logic           cam_pclk,
    input  logic           nreset,
    cam_bin_capture_if.slave bus
);

    localparam int PIX_CW  = $clog2(LINE_PIX) + 1;
    localparam int LINE_CW = $clog2(MAX_LINES) + 1;
    localparam logic [PIX_CW-1:0]  PIX_LIM  = PIX_CW'(LINE_PIX);
    localparam logic [LINE_CW-1:0] LINE_LIM = LINE_CW'(MAX_LINES);
    localparam logic [ADDR_W-1:0]  ADDR_MAX = '1;

    cam_state_e         r_state;
    cam_state_e         w_state_nxt;
    logic               r_vsync_prev;
    logic               r_href_prev;
    logic               r_end_pend;
    logic               r_phase;
    logic [DECIM_W-1:0] r_dcnt;
    logic               r_line_drop;
    logic [PIX_CW-1:0]  r_pix_cnt;
    logic [LINE_CW-1:0] r_line_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_word_cnt;
    logic               r_overflow;
    logic               r_frame_done;
    logic [ADDR_W-1:0]  r_lines_cap;
    logic [ADDR_W-1:0]  r_words_wr;

    logic               w_vsync_rise;
    logic               w_vsync_fall;
    logic               w_href_rise;
    logic               w_href_fall;
    logic               w_frame_start;
    logic               w_line_start;
    logic               w_in_line;
    logic               w_do_flush;
    logic               w_do_end;
    logic               w_byte;
    logic               w_phase;
    logic               w_is_luma;
    logic [DECIM_W-1:0] w_dcnt;
    logic               w_drop;
    logic [PIX_CW-1:0]  w_pix_cnt;
    logic               w_keep_cand;
    logic               w_keep;
    logic               w_pix_ovf;
    logic               w_line_ovf;
    logic               w_bit;
    logic               w_we;
    logic [WORD_W-1:0]  w_word;
    logic [ADDR_W-1:0]  w_word_cnt_nxt;

    assign w_vsync_rise = !r_vsync_prev &&  bus.cam_vsync;
    assign w_vsync_fall =  r_vsync_prev && !bus.cam_vsync;
    assign w_href_rise  = !r_href_prev  &&  bus.cam_href;
    assign w_href_fall  =  r_href_prev  && !bus.cam_href;

    always_ff @(posedge cam_pclk) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_vsync_fall) w_state_nxt = ARMED;
            ARMED: begin
                if (w_vsync_rise)     w_state_nxt = END;
                else if (w_href_rise) w_state_nxt = LINE;
            end
            LINE:    if (w_vsync_rise || w_href_fall) w_state_nxt = FLUSH;
            // A vsync rise seen during the line (r_end_pend) or now still ends the frame
            FLUSH:   w_state_nxt = (r_end_pend || w_vsync_rise) ? END : ARMED;
            END:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_frame_start = (r_state == IDLE) && w_vsync_fall;
        w_line_start  = (r_state == ARMED) && w_href_rise && !w_vsync_rise;
        w_in_line     = ((r_state == LINE) && !w_vsync_rise) || w_line_start;
        w_do_flush    = (r_state == FLUSH);
        w_do_end      = (r_state == END);
    end

    // The byte on the href-rise cycle is the first of the line, so line-local
    // counters are taken as restarted in that same cycle.
    assign w_byte      = w_in_line && bus.cam_href;
    assign w_phase     = w_line_start ? PHASE_FIRST : r_phase;
    assign w_is_luma   = w_byte && (w_phase == luma_phase(Y_FIRST));
    assign w_dcnt      = w_line_start ? '0 : r_dcnt;
    assign w_drop      = w_line_start ? (r_line_cnt == LINE_LIM) : r_line_drop;
    assign w_pix_cnt   = w_line_start ? '0 : r_pix_cnt;
    assign w_keep_cand = w_is_luma && (w_dcnt == '0) && !w_drop;
    assign w_keep      = w_keep_cand && (w_pix_cnt != PIX_LIM);
    assign w_pix_ovf   = w_keep_cand && (w_pix_cnt == PIX_LIM);
    assign w_line_ovf  = w_line_start && (r_line_cnt == LINE_LIM);
    assign w_bit       = (bus.cam_data >= bus.thresh) ^ bus.invert;

    bit_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk          (cam_pclk),
        .nreset       (nreset),
        .i_clear      (w_frame_start),
        .i_bit_valid  (w_keep),
        .i_bit        (w_bit),
        .i_flush      (w_do_flush),
        .o_word_valid (w_we),
        .o_word       (w_word)
    );

    assign w_word_cnt_nxt = (w_we && (r_word_cnt != ADDR_MAX)) ? r_word_cnt + 1'b1 : r_word_cnt;

    always_ff @(posedge cam_pclk) begin
        if (!nreset) begin
            r_vsync_prev <= 1'b0;
            r_href_prev  <= 1'b0;
            r_end_pend   <= 1'b0;
            r_phase      <= PHASE_FIRST;
            r_dcnt       <= '0;
            r_line_drop  <= 1'b0;
            r_pix_cnt    <= '0;
        end else begin
            r_vsync_prev <= bus.cam_vsync;
            r_href_prev  <= bus.cam_href;
            r_end_pend   <= (r_state == LINE) && w_vsync_rise;
            r_phase      <= w_byte ? ~w_phase : w_phase;
            r_dcnt       <= w_is_luma ? ((w_dcnt == bus.decim) ? '0 : w_dcnt + 1'b1) : w_dcnt;
            r_line_drop  <= w_drop;
            r_pix_cnt    <= w_keep ? w_pix_cnt + 1'b1 : w_pix_cnt;
        end
    end

    always_ff @(posedge cam_pclk) begin
        if (!nreset) begin
            r_line_cnt <= '0;
            r_addr     <= '0;
            r_word_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_frame_start) begin
            r_line_cnt <= '0;
            r_addr     <= '0;
            r_word_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_flush && (r_pix_cnt != '0)) begin
                r_line_cnt <= r_line_cnt + 1'b1;
            end
            // Address saturates at the top of the buffer rather than wrapping
            if (w_we && (r_addr != ADDR_MAX)) begin
                r_addr <= r_addr + 1'b1;
            end
            r_word_cnt <= w_word_cnt_nxt;
            if (w_pix_ovf || w_line_ovf || (w_we && (r_addr == ADDR_MAX))) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge cam_pclk) begin
        if (!nreset) begin
            r_frame_done <= 1'b0;
            r_lines_cap  <= '0;
            r_words_wr   <= '0;
        end else begin
            r_frame_done <= w_do_end;
            if (w_do_end) begin
                // A flush word may be on the port during END; count it in.
                r_lines_cap <= ADDR_W'(r_line_cnt);
                r_words_wr  <= w_word_cnt_nxt;
            end
        end
    end

    assign bus.mem_we         = w_we;
    assign bus.mem_addr       = r_addr;
    assign bus.mem_wdata      = w_word;
    assign bus.frame_done     = r_frame_done;
    assign bus.lines_captured = r_lines_cap;
    assign bus.words_written  = r_words_wr;
    assign bus.overflow       = r_overflow;

endmodule
